gfx_word_serializer: RTL and testbench
======================================

# gfx_word_serializer

Single-clock pixel fetcher that drives the 32-bit read port of the packed graphics line/tile memory and converts each returned word into eight 4-bit pixels on a ready/valid stream. It sits directly downstream of the memory read port, in the memory's read-clock domain, and feeds the palette/priority mixer. It hides the memory's 2-cycle read latency with credit-based prefetch into a 4-word buffer, so the pixel stream stays gap-free while the consumer accepts.

## Interface
- `MEM_LAT`, 2: memory read latency in cycles, from `rden` to valid `q`.
- `BUF_DEPTH`, 4: word buffer depth; also the maximum number of outstanding reads plus buffered words.
- `clk`  in  1  clock; the memory read clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; accepted only in IDLE.
- `base_addr`  in  8  first word address; sampled on `start`.
- `word_cnt`  in  8  number of words to fetch; 0 means 256; sampled on `start`.
- `abort`  in  1  synchronous cancel; returns the block to IDLE next cycle.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse after the last pixel handshake.
- `mem_rden`  out  1  to memory `rden`.
- `mem_addr`  out  8  to memory `rdaddress`.
- `mem_q`  in  32  from memory `q`.
- `pix_valid`  out  1  pixel available.
- `pix_ready`  in  1  consumer accepts.
- `pix_data`  out  4  pixel nibble.
- `pix_last`  out  1  marks the final pixel of the request.

## Operation
- States:
  - IDLE: on `start`, load the address counter and words-left counter, then go to FETCH.
  - FETCH: issue reads. When words-left reaches 0, go to DRAIN.
  - DRAIN: wait for the buffer and all in-flight reads to empty and the last pixel to be accepted, then pulse `done` and go to IDLE.
- Read issue condition: state is FETCH, words-left is non-zero, and buffer occupancy plus in-flight count is less than `BUF_DEPTH`.
- On each issue:
  - `mem_rden` goes high for one cycle with `mem_addr` set to the address counter.
  - The address counter increments modulo 256, so 255 wraps to 0.
  - The words-left counter decrements.
- In-flight tracking: a `MEM_LAT`-deep valid shift register. Its output pushes `mem_q` into the buffer. The push can never overflow because of the credit rule.
- Unpack: the head word is emitted as nibbles in order [3:0], [7:4], …, [31:28], indexed by a 3-bit nibble counter. When nibble 7 is handshaken, the head word pops and the counter returns to 0.
- `pix_valid` equals "buffer not empty". `pix_data` and `pix_valid` must stay stable while `pix_valid` is high and `pix_ready` is low.
- `pix_last` is high when the head is the final word of the request, the nibble index is 7, and `pix_valid` is high.
- Simultaneous push and pop in one cycle: occupancy is unchanged.
- `start` while busy is ignored.
- `abort` has priority over every other input. It clears the state, counters, buffer, nibble index and in-flight bits. Memory data that was already in flight is dropped. No `done` pulse is produced.
- Reset values: `busy`=0, `done`=0, `mem_rden`=0, `mem_addr`=0, `pix_valid`=0, `pix_data`=0, `pix_last`=0. Reset asserted mid-request behaves like `abort`.

## Timing
- `start` at cycle T produces the first `mem_rden` at T+1.
- A read issued at cycle N produces a buffer push at the end of N+`MEM_LAT`. The first `pix_valid` therefore appears at T+1+`MEM_LAT`+1, i.e. T+4 with defaults.
- Sustained throughput is 1 pixel per cycle. There are no bubbles while `pix_ready` stays high, because one word covers 8 cycles.
- `done` is asserted the cycle after the `pix_last` handshake.
- Outputs are registered, except `pix_valid`, `pix_data` and `pix_last`, which are decoded from registered buffer state.

## Configuration
- `GFX_SER_FLIP_EN` defined:
  - Adds input port `flip` (1 bit), sampled on `start`.
  - When `flip`=1, the address counter decrements instead of incrementing (0 wraps to 255).
  - When `flip`=1, nibbles are emitted in order [31:28] down to [3:0].
- Not defined: the port is absent and behaviour is ascending only.

## Structure
- Shared package `gfx_pkg` holds:
  - `GFX_MEM_LAT`=2, `GFX_BUF_DEPTH`=4, `GFX_NIB_PER_WORD`=8;
  - the state enum (IDLE/FETCH/DRAIN);
  - the nibble and word width constants.
- One sub-module: `gfx_word_fifo`, a synchronous 4x32 FIFO with push, pop, count, empty and full, plus async active-low reset and a synchronous clear used by `abort`.

## Test plan
- `base_addr`=0x10, `word_cnt`=1, memory word 0x76543210, `pix_ready`=1 → pixels 0,1,…,7 on consecutive cycles starting at T+4, `pix_last` on pixel 7, `done` one cycle later.
- `base_addr`=0xFE, `word_cnt`=3 → `mem_addr` sequence FE, FF, 00; 24 pixels with no gaps.
- `word_cnt`=0 → exactly 256 reads and 2048 pixels, then `done`.
- `pix_ready` held low for 20 cycles mid-request → never more than 4 words buffered plus in flight; `pix_data` stable during the stall; no word lost or duplicated.
- `abort`, and separately `rst_n` low, two cycles after the first read → next cycle `busy`=0 and `pix_valid`=0; late memory data is ignored; a new `start` works normally.
- With `GFX_SER_FLIP_EN` defined, `flip`=1, `base_addr`=0x01, `word_cnt`=2, words 0x76543210 → addresses 01, 00; pixels 7…0 for each word.

Source files
------------

// File: rtl/gfx_pkg.sv
// Shared constants, state encoding and helpers for the graphics word serializer.
package gfx_pkg;

  localparam int GFX_MEM_LAT      = 2;
  localparam int GFX_BUF_DEPTH    = 4;
  localparam int GFX_NIB_PER_WORD = 8;
  localparam int GFX_NIB_W        = 4;
  localparam int GFX_WORD_W       = 32;
  localparam int GFX_ADDR_W       = 8;

  typedef enum logic [1:0] {
    GFX_IDLE  = 2'd0,
    GFX_FETCH = 2'd1,
    GFX_DRAIN = 2'd2
  } gfx_state_e;

  // Next word address; descending order wraps 0 -> 255, ascending wraps 255 -> 0.
  function automatic logic [GFX_ADDR_W-1:0] gfx_next_addr(input logic [GFX_ADDR_W-1:0] addr,
                                                          input logic                  down);
    if (down) begin
      return addr - 8'd1;
    end else begin
      return addr + 8'd1;
    end
  endfunction

endpackage

// File: rtl/gfx_word_serializer_if.sv
// Memory read port and pixel stream bundle of the graphics word serializer.
// master = serializer side, slave = memory/consumer side.
interface gfx_word_serializer_if;
  import gfx_pkg::*;

  logic                      mem_rden;
  logic [GFX_ADDR_W-1:0]     mem_addr;
  logic [GFX_WORD_W-1:0]     mem_q;
  logic                      pix_valid;
  logic                      pix_ready;
  logic [GFX_NIB_W-1:0]      pix_data;
  logic                      pix_last;

  modport master (
    output mem_rden, mem_addr, pix_valid, pix_data, pix_last,
    input  mem_q, pix_ready
  );

  modport slave (
    input  mem_rden, mem_addr, pix_valid, pix_data, pix_last,
    output mem_q, pix_ready
  );

endinterface

// File: rtl/gfx_word_fifo.sv
// Small synchronous word FIFO with async reset and a synchronous clear.
// Read data is the head word, visible combinationally from registered storage.
module gfx_word_fifo
  import gfx_pkg::*;
#(
  parameter int DEPTH = GFX_BUF_DEPTH,
  parameter int WIDTH = GFX_WORD_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW:0]      count_r;
  logic             empty_s;
  logic             full_s;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty_s   = (count_r == (PW+1)'(0));
  assign full_s    = (count_r == (PW+1)'(DEPTH));
  assign do_push_s = push && !full_s;
  assign do_pop_s  = pop && !empty_s;

  // Storage write: data lands at the write pointer on every accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push_s && !clr) begin
      mem_r[wr_ptr_r] <= wdata;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointers and occupancy; clear drops all content, push+pop keeps occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= (PW+1)'(0);
    end else if (clr) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= (PW+1)'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;
  assign empty = empty_s;
  assign full  = full_s;

endmodule

// File: rtl/gfx_word_serializer.sv
// Graphics word serializer: credit-based prefetch of packed 32-bit words from
// the line/tile memory, unpacked into a gap-free stream of 4-bit pixels.
// Optional feature macro: GFX_SER_FLIP_EN adds the 'flip' port (descending
// addresses and nibble order [31:28] first).
module gfx_word_serializer
  import gfx_pkg::*;
#(
  parameter int MEM_LAT   = GFX_MEM_LAT,
  parameter int BUF_DEPTH = GFX_BUF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [GFX_ADDR_W-1:0] base_addr,
  input  logic [7:0]            word_cnt,
  input  logic                  abort,
`ifdef GFX_SER_FLIP_EN
  input  logic                  flip,
`endif
  output logic                  busy,
  output logic                  done,
  gfx_word_serializer_if.master bus
);

  localparam logic [1:0] ST_IDLE  = GFX_IDLE;
  localparam logic [1:0] ST_FETCH = GFX_FETCH;
  localparam logic [1:0] ST_DRAIN = GFX_DRAIN;

  logic [1:0]            state_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  rden_r;
  logic [GFX_ADDR_W-1:0] mem_addr_r;
  logic [GFX_ADDR_W-1:0] addr_cnt_r;
  logic [8:0]            words_left_r;
  logic [8:0]            emit_left_r;
  logic [2:0]            nib_r;
  logic [MEM_LAT-1:0]    vld_r;
  logic                  flip_r;

  logic                  flip_in_s;
  logic [8:0]            tot_s;
  logic [3:0]            inflight_s;
  logic [3:0]            used_s;
  logic                  credit_ok_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  pix_hs_s;
  logic                  pix_valid_s;
  logic                  pix_last_s;
  logic                  last_hs_s;
  logic [2:0]            nib_idx_s;
  logic [GFX_WORD_W-1:0] head_s;
  logic [2:0]            fifo_count_s;
  logic                  fifo_empty_s;
  logic                  fifo_full_s;

`ifdef GFX_SER_FLIP_EN
  assign flip_in_s = flip;
`else
  assign flip_in_s = 1'b0;
`endif

  // A word count of 0 requests the full 256-word address space.
  assign tot_s = (word_cnt == 8'd0) ? 9'd256 : {1'b0, word_cnt};

  // Outstanding reads: the one on the port this cycle plus those in the latency pipe.
  always_comb begin
    inflight_s = {3'b000, rden_r};
    for (int i = 0; i < MEM_LAT; i++) begin
      inflight_s = inflight_s + {3'b000, vld_r[i]};
    end
  end

  assign used_s      = {1'b0, fifo_count_s} + inflight_s;
  assign credit_ok_s = (used_s < 4'(BUF_DEPTH)) && !fifo_full_s;

  assign push_s      = vld_r[MEM_LAT-1];
  assign pix_valid_s = !fifo_empty_s;
  assign pix_hs_s    = pix_valid_s && bus.pix_ready;
  assign pop_s       = pix_hs_s && (nib_r == 3'(GFX_NIB_PER_WORD - 1));
  assign pix_last_s  = pix_valid_s && (nib_r == 3'(GFX_NIB_PER_WORD - 1)) && (emit_left_r == 9'd1);
  assign last_hs_s   = pix_last_s && bus.pix_ready;
  assign nib_idx_s   = flip_r ? (3'd7 - nib_r) : nib_r;

  gfx_word_fifo #(
    .DEPTH (GFX_BUF_DEPTH),
    .WIDTH (GFX_WORD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (abort),
    .push  (push_s),
    .wdata (bus.mem_q),
    .pop   (pop_s),
    .rdata (head_s),
    .count (fifo_count_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s)
  );

  // Control FSM and read issue; the first read leaves IDLE together with start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      rden_r       <= 1'b0;
      mem_addr_r   <= 8'd0;
      addr_cnt_r   <= 8'd0;
      words_left_r <= 9'd0;
      flip_r       <= 1'b0;
    end else if (abort) begin
      state_r      <= ST_IDLE;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      rden_r       <= 1'b0;
      mem_addr_r   <= 8'd0;
      addr_cnt_r   <= 8'd0;
      words_left_r <= 9'd0;
      flip_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      rden_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            rden_r       <= 1'b1;
            mem_addr_r   <= base_addr;
            addr_cnt_r   <= gfx_next_addr(base_addr, flip_in_s);
            words_left_r <= tot_s - 9'd1;
            flip_r       <= flip_in_s;
            state_r      <= ST_FETCH;
            busy_r       <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (words_left_r == 9'd0) begin
            state_r <= ST_DRAIN;
          end else if (credit_ok_s) begin
            rden_r       <= 1'b1;
            mem_addr_r   <= addr_cnt_r;
            addr_cnt_r   <= gfx_next_addr(addr_cnt_r, flip_r);
            words_left_r <= words_left_r - 9'd1;
          end
        end
        ST_DRAIN: begin
          // The final pixel handshake implies buffer and pipe are empty.
          if (last_hs_s) begin
            done_r  <= 1'b1;
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Latency pipe, nibble index and remaining-word count on the pixel side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r       <= {MEM_LAT{1'b0}};
      nib_r       <= 3'd0;
      emit_left_r <= 9'd0;
    end else if (abort) begin
      vld_r       <= {MEM_LAT{1'b0}};
      nib_r       <= 3'd0;
      emit_left_r <= 9'd0;
    end else begin
      vld_r <= {vld_r[MEM_LAT-2:0], rden_r};
      if (state_r == ST_IDLE && start) begin
        emit_left_r <= tot_s;
      end else if (pop_s) begin
        emit_left_r <= emit_left_r - 9'd1;
      end else begin
        emit_left_r <= emit_left_r;
      end
      if (pix_hs_s) begin
        nib_r <= nib_r + 3'd1;
      end else begin
        nib_r <= nib_r;
      end
    end
  end

  assign busy          = busy_r;
  assign done          = done_r;
  assign bus.mem_rden  = rden_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.pix_valid = pix_valid_s;
  assign bus.pix_data  = pix_valid_s ? head_s[{nib_idx_s, 2'b00} +: GFX_NIB_W] : 4'd0;
  assign bus.pix_last  = pix_last_s;

endmodule

// File: tb/tb_gfx_word_serializer.sv
// Randomized bench for gfx_word_serializer with a request-level reference model:
// each start expands into the expected address list and nibble list directly
// from the memory contents; one negedge process compares every cycle.
module tb_gfx_word_serializer;
  import gfx_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] base_addr;
  logic [7:0] word_cnt;
`ifdef GFX_SER_FLIP_EN
  logic       flip;
`endif
  logic       busy;
  logic       done;

  gfx_word_serializer_if bus();

  gfx_word_serializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .word_cnt  (word_cnt),
    .abort     (abort),
`ifdef GFX_SER_FLIP_EN
    .flip      (flip),
`endif
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory with a 2-cycle read latency
  logic [31:0] mem [256];
  logic [31:0] q_p1;
  always @(posedge clk) begin
    if (bus.mem_rden) q_p1 <= mem[bus.mem_addr];
    bus.mem_q <= q_p1;
  end

  // Consumer: 0 = always ready, 1 = random, 2 = stalled
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.pix_ready = 1'b1;
      1:       bus.pix_ready = ($urandom_range(0, 3) != 0);
      default: bus.pix_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h expected=0x%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Reference model state
  logic [3:0] exp_pix [$];
  logic [7:0] exp_addr [$];
  int  issued = 0, popped = 0, nib_seen = 0;
  bit  last_hs_prev = 0, stall_prev = 0;
  logic [3:0] prev_data = 4'd0;
  bit  first_pix_pend = 0, first_rd_pend = 0;
  int  start_cyc = 0, first_pix_cyc = 0, last_hs_cyc = 0;
  int  rd_total = 0, pix_total = 0;

  always @(negedge clk) begin
    if (!rst_n || abort) begin
      exp_pix.delete();
      exp_addr.delete();
      issued = 0; popped = 0; nib_seen = 0;
      last_hs_prev = 0; stall_prev = 0;
      first_pix_pend = 0; first_rd_pend = 0;
    end else begin
      bit last_hs;
      last_hs = 0;
      check("done_pulse", done, last_hs_prev);
      if (bus.mem_rden) begin
        rd_total++;
        issued++;
        if (exp_addr.size() == 0) check("spurious_read", bus.mem_rden, 0);
        else check("rd_addr", bus.mem_addr, exp_addr.pop_front());
        check("credit_bound", (issued - popped) <= 4, 1);
        if (first_rd_pend) begin
          check("first_rd_lat", cyc - start_cyc, 1);
          first_rd_pend = 0;
        end
      end
      if (bus.pix_valid) begin
        if (exp_pix.size() == 0) begin
          check("unexpected_pix", bus.pix_valid, 0);
        end else begin
          if (stall_prev) check("stall_stable", bus.pix_data, prev_data);
          check("pix_data", bus.pix_data, exp_pix[0]);
          check("pix_last", bus.pix_last, exp_pix.size() == 1);
          if (first_pix_pend) begin
            check("first_pix_lat", cyc - start_cyc, 4);
            first_pix_cyc  = cyc;
            first_pix_pend = 0;
          end
          if (bus.pix_ready) begin
            void'(exp_pix.pop_front());
            pix_total++;
            nib_seen++;
            if (nib_seen == 8) begin
              nib_seen = 0;
              popped++;
            end
            if (exp_pix.size() == 0) begin
              last_hs     = 1;
              last_hs_cyc = cyc;
            end
          end
        end
      end else if (stall_prev) begin
        check("stall_valid", bus.pix_valid, 1);
      end
      stall_prev   = bus.pix_valid && !bus.pix_ready;
      prev_data    = bus.pix_data;
      last_hs_prev = last_hs;
    end
  end

  task automatic start_req(input logic [7:0] b, input logic [7:0] c, input logic fl);
    int n;
    logic [31:0] w;
    logic [7:0] a;
    n = (c == 8'd0) ? 256 : int'(c);
    for (int i = 0; i < n; i++) begin
      a = fl ? (b - 8'(i)) : (b + 8'(i));
      exp_addr.push_back(a);
      w = mem[a];
      for (int k = 0; k < 8; k++) exp_pix.push_back(fl ? w[(7-k)*4 +: 4] : w[k*4 +: 4]);
    end
    start = 1'b1;
    base_addr = b;
    word_cnt = c;
`ifdef GFX_SER_FLIP_EN
    flip = fl;
`endif
    start_cyc = cyc;
    first_pix_pend = 1;
    first_rd_pend = 1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check({name, "_done_seen"}, seen, 1);
    if (seen) check({name, "_idle_at_done"}, busy, 0);
    @(posedge clk); #1;
  endtask

  int rd0, pix0;
  logic fl_r;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = 8'd0; word_cnt = 8'd0;
`ifdef GFX_SER_FLIP_EN
    flip = 1'b0;
`endif
    bus.pix_ready = 1'b1;
    q_p1 = 32'd0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h10] = 32'h76543210;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rden", bus.mem_rden, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_valid", bus.pix_valid, 0);
    check("rst_data", bus.pix_data, 0);
    check("rst_last", bus.pix_last, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single word, nibbles 0..7
    start_req(8'h10, 8'd1, 1'b0);
    check("model_nib0", exp_pix[0], 4'h0);
    check("model_nib7", exp_pix[7], 4'h7);
    check("model_addr0", exp_addr[0], 8'h10);
    wait_done("t1", 200);
    check("t1_span", last_hs_cyc - first_pix_cyc, 7);

    // Address wrap FE, FF, 00 with no gaps
    start_req(8'hFE, 8'd3, 1'b0);
    check("model_wrap_a1", exp_addr[1], 8'hFF);
    check("model_wrap_a2", exp_addr[2], 8'h00);
    wait_done("t2", 300);
    check("t2_span", last_hs_cyc - first_pix_cyc, 23);

    // word_cnt 0 means 256 words
    rd0 = rd_total; pix0 = pix_total;
    start_req(8'($urandom), 8'd0, 1'b0);
    wait_done("t3", 3000);
    check("t3_reads", rd_total - rd0, 256);
    check("t3_pixels", pix_total - pix0, 2048);
    check("t3_span", last_hs_cyc - first_pix_cyc, 2047);

    // 20-cycle consumer stall mid-request
    pix0 = pix_total;
    start_req(8'($urandom), 8'd6, 1'b0);
    repeat (12) @(posedge clk);
    #1 rdy_mode = 2;
    repeat (20) @(posedge clk);
    #1 rdy_mode = 0;
    wait_done("t4", 500);
    check("t4_pixels", pix_total - pix0, 48);

    // Abort shortly after the first read
    start_req(8'($urandom), 8'd10, 1'b0);
    repeat (2) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_valid", bus.pix_valid, 0);
    repeat (10) @(posedge clk);
    #1;
    start_req(8'($urandom), 8'd2, 1'b0);
    wait_done("t5", 300);

    // Reset asserted mid-request
    start_req(8'($urandom), 8'd10, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_valid", bus.pix_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    start_req(8'($urandom), 8'd2, 1'b0);
    wait_done("t6", 300);

    // Randomized requests with a random consumer
    rdy_mode = 1;
    for (int r = 0; r < 8; r++) begin
`ifdef GFX_SER_FLIP_EN
      fl_r = 1'($urandom_range(0, 1));
`else
      fl_r = 1'b0;
`endif
      start_req(8'($urandom), 8'($urandom_range(1, 12)), fl_r);
      wait_done("rand", 1500);
    end
    rdy_mode = 0;
    @(posedge clk); #1;

`ifdef GFX_SER_FLIP_EN
    // Descending addresses and reversed nibble order
    mem[8'h01] = 32'h76543210;
    mem[8'h00] = 32'h76543210;
    start_req(8'h01, 8'd2, 1'b1);
    check("model_flip_a1", exp_addr[1], 8'h00);
    check("model_flip_nib0", exp_pix[0], 4'h7);
    check("model_flip_nib15", exp_pix[15], 4'h0);
    wait_done("t8", 300);
    check("t8_span", last_hs_cyc - first_pix_cyc, 15);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
